// File: rtl/hazard_pkg.sv
// Shared forward-select encodings and the multiplier tracker entry type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_MUL = 2'b11;

    // Widest register address the tracker can hold; narrower addresses are zero-extended.
    localparam int RD_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
    } mul_entry_t;

endpackage

// File: rtl/mul_tracker.sv
// Shift register following each accepted multiply through the MUL_LAT-stage multiplier.
module mul_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [RD_MAX_W-1:0]         load_rd,
    output logic [MUL_LAT-1:0]          entry_valid,
    output logic [MUL_LAT*RD_MAX_W-1:0] entry_rd,
    output logic                        last_valid,
    output logic [RD_MAX_W-1:0]         last_rd
);

    mul_entry_t [MUL_LAT-1:0] pipe;
    mul_entry_t               head;

    // Non-accepted cycles shift in an all-zero bubble so rd never carries stale data.
    always_comb begin
        head.valid = load;
        head.rd    = load ? load_rd : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[MUL_LAT-2:0], head};
        end
    end

    for (genvar j = 0; j < MUL_LAT; j++) begin : g_out
        assign entry_valid[j]                    = pipe[j].valid;
        assign entry_rd[j*RD_MAX_W +: RD_MAX_W] = pipe[j].rd;
    end

    assign last_valid = pipe[MUL_LAT-1].valid;
    assign last_rd    = pipe[MUL_LAT-1].rd;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard and forwarding control: load-use, MUL RAW/WAW stalls, per-source
// forward selects, and multiplier write-back tracking.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          issue_regwrite,
    input  logic                          issue_is_mul,
    input  logic                          flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic [REG_ADDR_W-1:0]         m_rd,
    input  logic [REG_ADDR_W-1:0]         w_rd,
    input  logic                          ex_is_load,
    input  logic                          m_regwrite,
    input  logic                          w_regwrite,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          mul_wb_valid,
    output logic [REG_ADDR_W-1:0]         mul_wb_rd,
    output logic [CNT_W-1:0]              stall_cycles
);

    localparam int W = REG_ADDR_W;

    logic [MUL_LAT-1:0]          ent_valid;
    logic [MUL_LAT*RD_MAX_W-1:0] ent_rd;
    logic                        last_valid;
    logic [RD_MAX_W-1:0]         last_rd;
    logic [NUM_SRC-1:0]          ld_hit;
    logic [NUM_SRC-1:0]          raw_hit;
    logic [2*NUM_SRC-1:0]        fwd_int;
    logic [RD_MAX_W-1:0]         issue_rd_ext;
    logic                        waw_hit;
    logic                        stall_int;
    logic                        accept;

    assign issue_rd_ext = RD_MAX_W'(issue_rd);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [W-1:0]        a;
        logic [RD_MAX_W-1:0] a_ext;
        logic                live;
        logic                raw;
        logic [1:0]          sel;

        assign a     = src_addr[i*W +: W];
        assign a_ext = RD_MAX_W'(a);
        assign live  = src_used[i] && (a != '0);

        assign ld_hit[i] = live && (a == ex_rd);

        // Entries before the last have no result yet; the last one is forwardable instead.
        always_comb begin
            raw = 1'b0;
            for (int j = 0; j < MUL_LAT - 1; j++) begin
                if (ent_valid[j] && (ent_rd[j*RD_MAX_W +: RD_MAX_W] == a_ext)) raw = 1'b1;
            end
            raw = raw && live;
        end

        always_comb begin
            sel = FWD_RF;
            if (live && last_valid && (a_ext == last_rd)) sel = FWD_MUL;
            else if (live && m_regwrite && (a == m_rd))   sel = FWD_MEM;
            else if (live && w_regwrite && (a == w_rd))   sel = FWD_WB;
        end

        assign raw_hit[i]        = raw;
        assign fwd_int[2*i +: 2] = sel;
    end

    always_comb begin
        waw_hit = 1'b0;
        for (int j = 0; j < MUL_LAT; j++) begin
            if (ent_valid[j] && (ent_rd[j*RD_MAX_W +: RD_MAX_W] == issue_rd_ext)) waw_hit = 1'b1;
        end
        waw_hit = waw_hit && issue_regwrite && (issue_rd != '0);
    end

    assign stall_int = issue_valid &&
                       ((ex_is_load && (ex_rd != '0) && (|ld_hit)) || (|raw_hit) || waw_hit);

    assign stall   = rst_n && stall_int;
    assign fwd_sel = rst_n ? fwd_int : '0;

    // Issue handshake: decode offers issue_valid; the instruction is taken on a cycle with
    // issue_valid && !stall && !flush, otherwise decode holds it and EX gets a bubble.
    assign accept = issue_valid && !stall && !flush && issue_is_mul &&
                    issue_regwrite && (issue_rd != '0);

    mul_tracker #(
        .MUL_LAT (MUL_LAT)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (accept),
        .load_rd     (issue_rd_ext),
        .entry_valid (ent_valid),
        .entry_rd    (ent_rd),
        .last_valid  (last_valid),
        .last_rd     (last_rd)
    );

    assign mul_wb_valid = last_valid;
    assign mul_wb_rd    = last_rd[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one task per scenario with inline checks.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_regwrite;
  logic        issue_is_mul;
  logic        flush;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [4:0]  ex_rd, m_rd, w_rd;
  logic        ex_is_load, m_regwrite, w_regwrite;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        mul_wb_valid;
  logic [4:0]  mul_wb_rd;
  logic [15:0] stall_cycles;
  logic [3:0]  fwd_sel_c;
  logic        stall_c;
  logic        mul_wb_valid_c;
  logic [4:0]  mul_wb_rd_c;
  logic [3:0]  stall_cycles_c;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_is_mul(issue_is_mul), .flush(flush),
    .src_addr(src_addr), .src_used(src_used), .ex_rd(ex_rd), .m_rd(m_rd), .w_rd(w_rd),
    .ex_is_load(ex_is_load), .m_regwrite(m_regwrite), .w_regwrite(w_regwrite),
    .fwd_sel(fwd_sel), .stall(stall), .mul_wb_valid(mul_wb_valid),
    .mul_wb_rd(mul_wb_rd), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_is_mul(issue_is_mul), .flush(flush),
    .src_addr(src_addr), .src_used(src_used), .ex_rd(ex_rd), .m_rd(m_rd), .w_rd(w_rd),
    .ex_is_load(ex_is_load), .m_regwrite(m_regwrite), .w_regwrite(w_regwrite),
    .fwd_sel(fwd_sel_c), .stall(stall_c), .mul_wb_valid(mul_wb_valid_c),
    .mul_wb_rd(mul_wb_rd_c), .stall_cycles(stall_cycles_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // driver tasks
  task automatic clear_inputs();
    issue_valid = 0; issue_rd = 0; issue_regwrite = 0; issue_is_mul = 0; flush = 0;
    src_addr = 0; src_used = 0; ex_rd = 0; m_rd = 0; w_rd = 0;
    ex_is_load = 0; m_regwrite = 0; w_regwrite = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic issue_mul(input logic [4:0] rd);
    issue_valid = 1; issue_is_mul = 1; issue_regwrite = 1; issue_rd = rd;
  endtask

  // scenarios
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    issue_valid = 1; ex_is_load = 1; ex_rd = 7; src_addr = {5'd0, 5'd7}; src_used = 2'b11;
    m_rd = 7; m_regwrite = 1;
    @(posedge clk); #2;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (fwd_sel !== 4'b0) begin n_errors++; $display("FAIL reset_fwd: got %b expected 0000", fwd_sel); end
    n_checks++; if (mul_wb_valid !== 1'b0) begin n_errors++; $display("FAIL reset_wbv: got %b expected 0", mul_wb_valid); end
    n_checks++; if (mul_wb_rd !== 5'd0) begin n_errors++; $display("FAIL reset_wbrd: got %0d expected 0", mul_wb_rd); end
    n_checks++; if (stall_cycles !== 16'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles); end
    n_checks++; if (stall_cycles_c !== 4'd0) begin n_errors++; $display("FAIL reset_cnt_c: got %0d expected 0", stall_cycles_c); end
  endtask

  task automatic test_mul_raw();
    do_reset();
    issue_mul(5);
    #2;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL raw_c0_stall: got %b expected 0", stall); end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      clear_inputs();
      if (c <= 3) begin
        issue_valid = 1; issue_regwrite = 1; issue_rd = 6; src_addr = {5'd1, 5'd5}; src_used = 2'b11;
      end
      #2;
      if (c < 3) begin
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL raw_c%0d_stall: got %b expected 1", c, stall); end
        n_checks++; if (mul_wb_valid !== 1'b0) begin n_errors++; $display("FAIL raw_c%0d_wbv: got %b expected 0", c, mul_wb_valid); end
      end else if (c == 3) begin
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL raw_c3_stall: got %b expected 0", stall); end
        n_checks++; if (fwd_sel !== 4'b0011) begin n_errors++; $display("FAIL raw_c3_fwd: got %b expected 0011", fwd_sel); end
        n_checks++; if (mul_wb_valid !== 1'b1) begin n_errors++; $display("FAIL raw_c3_wbv: got %b expected 1", mul_wb_valid); end
        n_checks++; if (mul_wb_rd !== 5'd5) begin n_errors++; $display("FAIL raw_c3_wbrd: got %0d expected 5", mul_wb_rd); end
        n_checks++; if (stall_cycles !== 16'd2) begin n_errors++; $display("FAIL raw_c3_cnt: got %0d expected 2", stall_cycles); end
      end else begin
        n_checks++; if (mul_wb_valid !== 1'b0) begin n_errors++; $display("FAIL raw_c4_wbv: got %b expected 0", mul_wb_valid); end
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue_valid = 1; issue_regwrite = 1; issue_rd = 2; src_addr = {5'd0, 5'd7}; src_used = 2'b01;
    ex_is_load = 1; ex_rd = 7;
    #2;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_c0_stall: got %b expected 1", stall); end
    n_checks++; if (fwd_sel !== 4'b0000) begin n_errors++; $display("FAIL lu_c0_fwd: got %b expected 0000", fwd_sel); end
    next_cycle();
    ex_is_load = 0; ex_rd = 0; m_rd = 7; m_regwrite = 1;
    #2;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_c1_stall: got %b expected 0", stall); end
    n_checks++; if (fwd_sel !== 4'b0001) begin n_errors++; $display("FAIL lu_c1_fwd: got %b expected 0001", fwd_sel); end
    n_checks++; if (stall_cycles !== 16'd1) begin n_errors++; $display("FAIL lu_c1_cnt: got %0d expected 1", stall_cycles); end
    // load-use and MUL RAW in the same cycle count as one stall
    next_cycle();
    clear_inputs();
    issue_mul(5);
    next_cycle();
    clear_inputs();
    issue_valid = 1; src_addr = {5'd1, 5'd5}; src_used = 2'b11; ex_is_load = 1; ex_rd = 1;
    #2;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL combo_stall: got %b expected 1", stall); end
    next_cycle();
    issue_valid = 0;
    #2;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL combo_novalid_stall: got %b expected 0", stall); end
    n_checks++; if (stall_cycles !== 16'd2) begin n_errors++; $display("FAIL combo_cnt: got %0d expected 2", stall_cycles); end
  endtask

  task automatic test_priority();
    do_reset();
    issue_mul(3);
    m_rd = 3; w_rd = 3; m_regwrite = 1; w_regwrite = 1; src_addr = {5'd3, 5'd0}; src_used = 2'b10;
    #2;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL prio_c0_stall: got %b expected 0", stall); end
    n_checks++; if (fwd_sel !== 4'b0100) begin n_errors++; $display("FAIL prio_mem_over_wb: got %b expected 0100", fwd_sel); end
    next_cycle();
    issue_valid = 0; issue_is_mul = 0; issue_regwrite = 0; issue_rd = 0;
    #2;
    n_checks++; if (fwd_sel !== 4'b0100) begin n_errors++; $display("FAIL prio_c1_fwd: got %b expected 0100", fwd_sel); end
    m_regwrite = 0;
    #2;
    n_checks++; if (fwd_sel !== 4'b1000) begin n_errors++; $display("FAIL prio_wb_only: got %b expected 1000", fwd_sel); end
    next_cycle();
    next_cycle();
    m_regwrite = 1;
    #2;
    n_checks++; if (fwd_sel !== 4'b1100) begin n_errors++; $display("FAIL prio_mul_over_mem: got %b expected 1100", fwd_sel); end
    src_used = 2'b00;
    #2;
    n_checks++; if (fwd_sel !== 4'b0000) begin n_errors++; $display("FAIL prio_unused: got %b expected 0000", fwd_sel); end
    src_used = 2'b10; src_addr = 10'd0; m_rd = 0; w_rd = 0;
    #2;
    n_checks++; if (fwd_sel !== 4'b0000) begin n_errors++; $display("FAIL prio_x0: got %b expected 0000", fwd_sel); end
    next_cycle();
    src_addr = {5'd3, 5'd0}; m_rd = 3; w_rd = 3;
    #2;
    n_checks++; if (fwd_sel !== 4'b0100) begin n_errors++; $display("FAIL prio_after_retire: got %b expected 0100", fwd_sel); end
  endtask

  task automatic test_waw();
    do_reset();
    issue_mul(9);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      clear_inputs();
      if (c <= 4) issue_mul(9);
      #2;
      if (c <= 3) begin
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL waw_c%0d_stall: got %b expected 1", c, stall); end
      end
      if (c == 3) begin
        n_checks++; if (mul_wb_valid !== 1'b1 || mul_wb_rd !== 5'd9) begin n_errors++; $display("FAIL waw_c3_wb: got %b/%0d expected 1/9", mul_wb_valid, mul_wb_rd); end
      end
      if (c == 4) begin
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL waw_c4_stall: got %b expected 0", stall); end
        n_checks++; if (stall_cycles !== 16'd3) begin n_errors++; $display("FAIL waw_c4_cnt: got %0d expected 3", stall_cycles); end
      end
      if (c >= 4 && c <= 6) begin
        n_checks++; if (mul_wb_valid !== 1'b0) begin n_errors++; $display("FAIL waw_c%0d_bubble: got %b expected 0", c, mul_wb_valid); end
      end
      if (c == 7) begin
        n_checks++; if (mul_wb_valid !== 1'b1 || mul_wb_rd !== 5'd9) begin n_errors++; $display("FAIL waw_c7_wb: got %b/%0d expected 1/9", mul_wb_valid, mul_wb_rd); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.delete();
    for (int c = 0; c <= 6; c++) begin
      clear_inputs();
      if (c <= 2) begin
        issue_mul(5'(10 + c));
        exp_q.push_back(5'(10 + c));
      end
      #2;
      if (c <= 2) begin
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL b2b_c%0d_stall: got %b expected 0", c, stall); end
      end
      if (c >= 3 && c <= 5) begin
        n_checks++;
        if (mul_wb_valid !== 1'b1 || exp_q.size() == 0) begin
          n_errors++; $display("FAIL b2b_c%0d_wbv: got %b expected 1", c, mul_wb_valid);
        end else if (mul_wb_rd !== exp_q[0]) begin
          n_errors++; $display("FAIL b2b_c%0d_wbrd: got %0d expected %0d", c, mul_wb_rd, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (c == 6) begin
        n_checks++; if (mul_wb_valid !== 1'b0 || exp_q.size() != 0) begin n_errors++; $display("FAIL b2b_c6_drain: got %b left %0d expected 0", mul_wb_valid, exp_q.size()); end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue_mul(4);
    flush = 1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      clear_inputs();
      issue_valid = 1; issue_regwrite = 1; issue_rd = 6; src_addr = {5'd0, 5'd4}; src_used = 2'b01;
      #2;
      n_checks++; if (stall !== 1'b0 || mul_wb_valid !== 1'b0) begin n_errors++; $display("FAIL flush_c%0d: stall/wbv got %b/%b expected 0/0", c, stall, mul_wb_valid); end
    end
    next_cycle();
    clear_inputs();
    issue_mul(8);
    next_cycle();
    clear_inputs();
    flush = 1;
    next_cycle();
    flush = 0;
    next_cycle();
    #2;
    n_checks++; if (mul_wb_valid !== 1'b1 || mul_wb_rd !== 5'd8) begin n_errors++; $display("FAIL flush_inflight: got %b/%0d expected 1/8", mul_wb_valid, mul_wb_rd); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    issue_mul(13);
    next_cycle();
    issue_mul(14);
    next_cycle();
    clear_inputs();
    issue_valid = 1; issue_regwrite = 1; issue_rd = 6; src_addr = {5'd0, 5'd13}; src_used = 2'b01;
    #2;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL rst_mid_c2_stall: got %b expected 1", stall); end
    next_cycle();
    #2;
    n_checks++; if (mul_wb_valid !== 1'b1 || stall_cycles !== 16'd1) begin n_errors++; $display("FAIL rst_mid_c3: wbv/cnt got %b/%0d expected 1/1", mul_wb_valid, stall_cycles); end
    rst_n = 0;
    ex_is_load = 1; ex_rd = 13; m_rd = 13; m_regwrite = 1;
    #2;
    n_checks++; if (stall !== 1'b0 || fwd_sel !== 4'b0) begin n_errors++; $display("FAIL rst_mid_gate: stall/fwd got %b/%b expected 0/0000", stall, fwd_sel); end
    n_checks++; if (mul_wb_valid !== 1'b0 || stall_cycles !== 16'd0) begin n_errors++; $display("FAIL rst_mid_clear: wbv/cnt got %b/%0d expected 0/0", mul_wb_valid, stall_cycles); end
    next_cycle();
    clear_inputs();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_checks++; if (mul_wb_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_after_%0d: wbv got %b expected 0", c, mul_wb_valid); end
      next_cycle();
    end
    n_checks++; if (stall_cycles !== 16'd0) begin n_errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_counter();
    do_reset();
    issue_valid = 1; src_addr = {5'd0, 5'd7}; src_used = 2'b01; ex_is_load = 1; ex_rd = 7;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (k == 14) begin
        n_checks++; if (stall_cycles_c !== 4'd14) begin n_errors++; $display("FAIL cnt_k14: got %0d expected 14", stall_cycles_c); end
      end
      if (k == 15) begin
        n_checks++; if (stall_cycles_c !== 4'd15) begin n_errors++; $display("FAIL cnt_k15: got %0d expected 15", stall_cycles_c); end
      end
      next_cycle();
    end
    #2;
    n_checks++; if (stall_cycles_c !== 4'd15) begin n_errors++; $display("FAIL cnt_sat: got %0d expected 15", stall_cycles_c); end
    n_checks++; if (stall_cycles !== 16'd20) begin n_errors++; $display("FAIL cnt_wide: got %0d expected 20", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_mul_raw();
    test_load_use();
    test_priority();
    test_waw();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
